osnt_sume_10g_rate_limiter: RTL and testbench

//  Per-port inter-packet-gap (IPG) shaper placed directly upstream of the 10G TX queue.

---
 rtl/osnt_sume_rl_pkg.sv | 25 ++
 rtl/osnt_sume_axis_skid_slice.sv | 97 +++++++++
 rtl/osnt_sume_10g_rate_limiter.sv | 192 +++++++++++++++++++
 tb/tb_osnt_sume_10g_rate_limiter.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/osnt_sume_rl_pkg.sv
// -----------------------------------------------------------------------------
// osnt_sume_rl_pkg
//  Shared definitions for the OSNT SUME 10G rate limiter (IPG shaper).
//  Contents:
//   rl_state_e      - shaper FSM state encoding (IDLE=0, PASS=1, GAP=2)
//   RL_STATE_W      - width of the state encoding
//   RL_DEFAULT_IPG  - default inter-packet gap in idle cycles, for software
//                     and integration code that needs a power-on value
// -----------------------------------------------------------------------------
package osnt_sume_rl_pkg;

   localparam int RL_STATE_W = 2;

   // IDLE: waiting for a packet head (gated by rl_enable)
   // PASS: mid-packet, beats flow regardless of rl_enable
   // GAP : enforcing idle cycles after the last beat of a packet
   typedef enum logic [RL_STATE_W-1:0] {
      RL_IDLE = 2'd0,
      RL_PASS = 2'd1,
      RL_GAP  = 2'd2
   } rl_state_e;

   localparam logic [31:0] RL_DEFAULT_IPG = 32'd12;

endpackage : osnt_sume_rl_pkg

// File: rtl/osnt_sume_axis_skid_slice.sv
// -----------------------------------------------------------------------------
// osnt_sume_axis_skid_slice
//  Two-entry AXI-Stream register slice. Data-agnostic: the caller packs
//  whatever sideband it needs into s_data / m_data.
//  - One cycle latency from an input handshake to m_valid.
//  - Full throughput while m_ready stays high.
//  - When m_ready drops, the beat already in flight is caught in the skid
//    register; s_ready then falls until the skid entry drains.
//  - m_valid / m_data come straight from flops; m_data is held while
//    m_valid & ~m_ready.
// Ports:
//  clk      in   clock
//  reset    in   synchronous, active-high; empties both entries
//  s_data   in   WIDTH  input payload
//  s_valid  in   input valid
//  s_ready  out  input ready (low only while both entries are occupied)
//  m_data   out  WIDTH  output payload
//  m_valid  out  output valid
//  m_ready  in   output ready
// -----------------------------------------------------------------------------
module osnt_sume_axis_skid_slice #(
   parameter int WIDTH = 201
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] s_data,
   input  logic             s_valid,
   output logic             s_ready,
   output logic [WIDTH-1:0] m_data,
   output logic             m_valid,
   input  logic             m_ready
);

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q,  out_data_d;
   logic             skid_valid_q, skid_valid_d;
   logic [WIDTH-1:0] skid_data_q,  skid_data_d;
   logic             in_fire;

   // s_ready depends only on a flop, so no combinational path runs from
   // m_ready back to the upstream stage.
   assign s_ready = ~skid_valid_q;
   assign in_fire = s_valid & ~skid_valid_q;

   always_comb begin
      // NOTE: every variable gets its hold value first so no path through
      // the block leaves it unassigned; otherwise a latch is inferred.
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;

      if (!out_valid_q || m_ready) begin
         // Output register is free (or being drained this cycle): refill it,
         // oldest beat first. s_ready is low while the skid holds a beat,
         // so in_fire cannot coincide with skid_valid_q.
         if (skid_valid_q) begin
            out_valid_d  = 1'b1;
            out_data_d   = skid_data_q;
            skid_valid_d = 1'b0;
         end else begin
            out_valid_d = in_fire;
            if (in_fire) begin
               out_data_d = s_data;
            end
         end
      end else if (in_fire) begin
         // Output stalled: park the incoming beat in the skid entry.
         skid_valid_d = 1'b1;
         skid_data_d  = s_data;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of every other flop.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_q  <= 1'b0;
         skid_valid_q <= 1'b0;
      end else begin
         out_valid_q  <= out_valid_d;
         skid_valid_q <= skid_valid_d;
      end
   end

   // NOTE: payload registers are not reset; they are only observed when the
   // matching valid flop is set, and leaving them out of reset keeps the
   // wide datapath off the reset network.
   always_ff @(posedge clk) begin
      out_data_q  <= out_data_d;
      skid_data_q <= skid_data_d;
   end

   assign m_valid = out_valid_q;
   assign m_data  = out_data_q;

endmodule : osnt_sume_axis_skid_slice

// File: rtl/osnt_sume_10g_rate_limiter.sv
// -----------------------------------------------------------------------------
// osnt_sume_10g_rate_limiter
//  Per-port inter-packet-gap shaper placed upstream of the 10G TX queue.
//  After each packet's last input beat the slave side is held not-ready for
//  ipg_cycles cycles; data is forwarded through a 2-entry register slice.
//  Optional build macro: OSNT_RATE_LIMIT_STATS_EN adds rl_stall_count.
// Ports:
//  axis_aclk       in   clock (156.25 MHz)
//  axis_reset      in   synchronous, active-high reset
//  s_axis_*        in/out  AXI-Stream slave (tdata/tkeep/tuser/tvalid/tlast in,
//                         tready out) from the generator/arbiter
//  m_axis_*        out/in  AXI-Stream master toward the TX queue
//  rl_enable       in   1 = new packets may start, 0 = hold at packet boundary
//  ipg_cycles      in   idle cycles enforced after each packet (sampled at tlast)
//  clear           in   synchronous clear of the counters
//  rl_pkt_count    out  packets accepted on s_axis (wraps)
//  rl_stall_count  out  cycles with s_axis_tvalid high during GAP (saturates);
//                       present only with OSNT_RATE_LIMIT_STATS_EN
// -----------------------------------------------------------------------------
module osnt_sume_10g_rate_limiter
   import osnt_sume_rl_pkg::*;
#(
   parameter int C_M_AXIS_DATA_WIDTH  = 64,
   parameter int C_S_AXIS_DATA_WIDTH  = 64,   // must equal the master width
   parameter int C_M_AXIS_TUSER_WIDTH = 128,
   parameter int C_S_AXIS_TUSER_WIDTH = 128,  // must equal the master width
   parameter int C_S_AXI_DATA_WIDTH   = 32
) (
   input  logic                              axis_aclk,
   input  logic                              axis_reset,

   input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
   input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
   input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
   input  logic                              s_axis_tvalid,
   output logic                              s_axis_tready,
   input  logic                              s_axis_tlast,

   output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
   output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
   output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
   output logic                              m_axis_tvalid,
   input  logic                              m_axis_tready,
   output logic                              m_axis_tlast,

   input  logic                              rl_enable,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]     ipg_cycles,
   input  logic                              clear,
   output logic [31:0]                       rl_pkt_count
`ifdef OSNT_RATE_LIMIT_STATS_EN
   ,
   output logic [31:0]                       rl_stall_count
`endif
);

   localparam int KEEP_W    = C_M_AXIS_DATA_WIDTH / 8;
   localparam int PAYLOAD_W = 1 + C_M_AXIS_TUSER_WIDTH + KEEP_W + C_M_AXIS_DATA_WIDTH;

   rl_state_e                     state_q, state_d;
   logic [C_S_AXI_DATA_WIDTH-1:0] gap_cnt_q, gap_cnt_d;
   logic [31:0]                   pkt_count_q, pkt_count_d;

   logic                          skid_ready;
   logic                          s_ready;
   logic                          s_fire;
   logic [PAYLOAD_W-1:0]          s_payload;
   logic [PAYLOAD_W-1:0]          m_payload;

   // ---------------------------------------------------------------------------
   // Input ready: rl_enable only gates packet heads (IDLE); a started packet
   // always completes.
   // ---------------------------------------------------------------------------
   always_comb begin
      s_ready = 1'b0;
      unique case (state_q)
         RL_IDLE: s_ready = rl_enable & skid_ready;
         RL_PASS: s_ready = skid_ready;
         RL_GAP:  s_ready = 1'b0;
         default: s_ready = 1'b0;
      endcase
   end

   assign s_fire        = s_axis_tvalid & s_ready;
   // Held low throughout reset, regardless of the state flop's pre-reset value.
   assign s_axis_tready = s_ready & ~axis_reset;

   // ---------------------------------------------------------------------------
   // Next-state / gap counter. The gap is counted on the input side, so
   // downstream backpressure can only lengthen the spacing seen on m_axis.
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      gap_cnt_d = gap_cnt_q;

      unique case (state_q)
         RL_IDLE, RL_PASS: begin
            if (s_fire) begin
               if (!s_axis_tlast) begin
                  state_d = RL_PASS;
               end else if (ipg_cycles != '0) begin
                  // ipg_cycles is sampled here only; later changes affect
                  // the next gap.
                  state_d   = RL_GAP;
                  gap_cnt_d = ipg_cycles;
               end else begin
                  state_d = RL_IDLE;
               end
            end
         end
         RL_GAP: begin
            gap_cnt_d = gap_cnt_q - 1'b1;
            if (gap_cnt_q == C_S_AXI_DATA_WIDTH'(1)) begin
               state_d = RL_IDLE;
            end
         end
         default: state_d = RL_IDLE;
      endcase
   end

   // Packet counter: clear wins over a same-cycle increment; wraps naturally.
   always_comb begin
      pkt_count_d = pkt_count_q;
      if (clear) begin
         pkt_count_d = '0;
      end else if (s_fire && s_axis_tlast) begin
         pkt_count_d = pkt_count_q + 32'd1;
      end
   end

   always_ff @(posedge axis_aclk) begin
      if (axis_reset) begin
         state_q     <= RL_IDLE;
         gap_cnt_q   <= '0;
         pkt_count_q <= '0;
      end else begin
         state_q     <= state_d;
         gap_cnt_q   <= gap_cnt_d;
         pkt_count_q <= pkt_count_d;
      end
   end

   assign rl_pkt_count = pkt_count_q;

`ifdef OSNT_RATE_LIMIT_STATS_EN
   // ---------------------------------------------------------------------------
   // Stall statistics: cycles a source is waiting on the shaper's gap.
   // ---------------------------------------------------------------------------
   logic [31:0] stall_count_q, stall_count_d;

   always_comb begin
      stall_count_d = stall_count_q;
      if (clear) begin
         stall_count_d = '0;
      end else if (s_axis_tvalid && (state_q == RL_GAP) && (stall_count_q != '1)) begin
         stall_count_d = stall_count_q + 32'd1;
      end
   end

   always_ff @(posedge axis_aclk) begin
      if (axis_reset) begin
         stall_count_q <= '0;
      end else begin
         stall_count_q <= stall_count_d;
      end
   end

   assign rl_stall_count = stall_count_q;
`else
   // Statistics disabled: no stall counter is built.
`endif

   // ---------------------------------------------------------------------------
   // Datapath: pack, slice, unpack. Only accepted beats enter the slice.
   // ---------------------------------------------------------------------------
   assign s_payload = {s_axis_tlast, s_axis_tuser, s_axis_tkeep, s_axis_tdata};

   osnt_sume_axis_skid_slice #(
      .WIDTH (PAYLOAD_W)
   ) u_skid (
      .clk     (axis_aclk),
      .reset   (axis_reset),
      .s_data  (s_payload),
      .s_valid (s_fire),
      .s_ready (skid_ready),
      .m_data  (m_payload),
      .m_valid (m_axis_tvalid),
      .m_ready (m_axis_tready)
   );

   assign {m_axis_tlast, m_axis_tuser, m_axis_tkeep, m_axis_tdata} = m_payload;

endmodule : osnt_sume_10g_rate_limiter

// File: tb/tb_osnt_sume_10g_rate_limiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_osnt_sume_10g_rate_limiter
//  Self-checking bench: beats accepted on s_axis are pushed to a scoreboard
//  queue and compared in order against beats leaving m_axis. Gap lengths are
//  measured on both sides from observed handshakes.
// -----------------------------------------------------------------------------
module tb_osnt_sume_10g_rate_limiter;

   localparam int DW = 64;
   localparam int KW = 8;
   localparam int UW = 128;
   localparam int PW = 1 + UW + KW + DW;

   logic          clk = 1'b0;
   logic          axis_reset;
   logic [DW-1:0] s_axis_tdata;
   logic [KW-1:0] s_axis_tkeep;
   logic [UW-1:0] s_axis_tuser;
   logic          s_axis_tvalid;
   logic          s_axis_tready;
   logic          s_axis_tlast;
   logic [DW-1:0] m_axis_tdata;
   logic [KW-1:0] m_axis_tkeep;
   logic [UW-1:0] m_axis_tuser;
   logic          m_axis_tvalid;
   logic          m_axis_tready = 1'b1;
   logic          m_axis_tlast;
   logic          rl_enable;
   logic [31:0]   ipg_cycles;
   logic          clear;
   logic [31:0]   rl_pkt_count;
`ifdef OSNT_RATE_LIMIT_STATS_EN
   logic [31:0]   rl_stall_count;
`endif

   always #5 clk = ~clk;

   osnt_sume_10g_rate_limiter dut (
      .axis_aclk      (clk),
      .axis_reset     (axis_reset),
      .s_axis_tdata   (s_axis_tdata),
      .s_axis_tkeep   (s_axis_tkeep),
      .s_axis_tuser   (s_axis_tuser),
      .s_axis_tvalid  (s_axis_tvalid),
      .s_axis_tready  (s_axis_tready),
      .s_axis_tlast   (s_axis_tlast),
      .m_axis_tdata   (m_axis_tdata),
      .m_axis_tkeep   (m_axis_tkeep),
      .m_axis_tuser   (m_axis_tuser),
      .m_axis_tvalid  (m_axis_tvalid),
      .m_axis_tready  (m_axis_tready),
      .m_axis_tlast   (m_axis_tlast),
      .rl_enable      (rl_enable),
      .ipg_cycles     (ipg_cycles),
      .clear          (clear),
      .rl_pkt_count   (rl_pkt_count)
`ifdef OSNT_RATE_LIMIT_STATS_EN
      ,
      .rl_stall_count (rl_stall_count)
`endif
   );

   // ---------------------------------------------------------------------------
   // Checking
   // ---------------------------------------------------------------------------
   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
   endtask

   // ---------------------------------------------------------------------------
   // Scoreboard and gap monitor (samples on the falling edge)
   // ---------------------------------------------------------------------------
   logic [PW-1:0] sb[$];
   logic [PW-1:0] m_payload, s_payload, m_prev, exp_beat;
   bit            m_stalled = 0;
   int            cyc = 0;
   int            s_hs = 0;
   bit            s_in_pkt = 0, m_in_pkt = 0, s_have_last = 0, m_have_last = 0;
   int            s_last_cyc = 0, m_last_cyc = 0;
   int            s_gap = -1, m_gap = -1;
   int            tready_mode = 0;   // 0: always ready, 1: toggle every cycle

   assign m_payload = {m_axis_tlast, m_axis_tuser, m_axis_tkeep, m_axis_tdata};
   assign s_payload = {s_axis_tlast, s_axis_tuser, s_axis_tkeep, s_axis_tdata};

   always @(negedge clk) begin
      cyc++;
      if (axis_reset) begin
         m_stalled   = 0;
         s_in_pkt    = 0;
         m_in_pkt    = 0;
         s_have_last = 0;
         m_have_last = 0;
      end else begin
         if (m_stalled) check("m_stable", 256'(m_payload), 256'(m_prev));
         if (m_axis_tvalid && m_axis_tready) begin
            check("sb_nonempty", 256'(sb.size() != 0), 256'(1));
            if (sb.size() != 0) begin
               exp_beat = sb.pop_front();
               check("m_beat", 256'(m_payload), 256'(exp_beat));
            end
            if (!m_in_pkt && m_have_last) m_gap = cyc - m_last_cyc - 1;
            m_in_pkt = !m_axis_tlast;
            if (m_axis_tlast) begin
               m_last_cyc  = cyc;
               m_have_last = 1;
            end
         end
         m_stalled = m_axis_tvalid && !m_axis_tready;
         m_prev    = m_payload;
         if (s_axis_tvalid && s_axis_tready) begin
            sb.push_back(s_payload);
            s_hs++;
            if (!s_in_pkt && s_have_last) s_gap = cyc - s_last_cyc - 1;
            s_in_pkt = !s_axis_tlast;
            if (s_axis_tlast) begin
               s_last_cyc  = cyc;
               s_have_last = 1;
            end
         end
      end
   end

   always @(posedge clk) begin
      #1;
      if (tready_mode == 1) m_axis_tready = ~m_axis_tready;
      else                  m_axis_tready = 1'b1;
   end

   // ---------------------------------------------------------------------------
   // Source tasks: inputs change 1 ns after the rising edge
   // ---------------------------------------------------------------------------
   task automatic present_beat(input bit last);
      s_axis_tdata  = {$urandom, $urandom};
      s_axis_tuser  = {$urandom, $urandom, $urandom, $urandom};
      s_axis_tkeep  = last ? 8'h0F : 8'hFF;
      s_axis_tlast  = last;
      s_axis_tvalid = 1'b1;
   endtask

   task automatic wait_accept();
      bit acc = 0;
      int budget = 400;
      while (!acc && budget > 0) begin
         @(negedge clk);
         acc = s_axis_tready;
         budget--;
         @(posedge clk);
         #1;
      end
      if (!acc) check("accept_timeout", 256'(acc), 256'(1));
   endtask

   task automatic drive_beat(input bit last);
      present_beat(last);
      wait_accept();
   endtask

   task automatic send_pkt(input int n);
      for (int i = 0; i < n; i++) drive_beat(i == n - 1);
   endtask

   task automatic idle_cycles(input int n);
      s_axis_tvalid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_drain(input string tag);
      int budget = 400;
      s_axis_tvalid = 1'b0;
      while (sb.size() != 0 && budget > 0) begin
         @(posedge clk);
         #1;
         budget--;
      end
      check(tag, 256'(sb.size()), 256'(0));
   endtask

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   int hs_before;

   initial begin
      axis_reset    = 1'b1;
      s_axis_tvalid = 1'b0;
      s_axis_tdata  = '0;
      s_axis_tkeep  = '0;
      s_axis_tuser  = '0;
      s_axis_tlast  = 1'b0;
      rl_enable     = 1'b1;
      ipg_cycles    = 32'd3;
      clear         = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_m_tvalid", 256'(m_axis_tvalid), 256'(0));
      check("rst_s_tready", 256'(s_axis_tready), 256'(0));
      check("rst_pkt_count", 256'(rl_pkt_count), 256'(0));
      axis_reset = 1'b0;
      @(negedge clk);
      check("idle_s_tready", 256'(s_axis_tready), 256'(1));
      @(posedge clk);
      #1;

      // 1: ipg=3, two 4-beat packets back-to-back
      send_pkt(4);
      send_pkt(4);
      wait_drain("t1_drain");
      check("t1_s_gap", 256'(s_gap), 256'(3));
      check("t1_m_gap", 256'(m_gap), 256'(3));
      check("t1_pkt_count", 256'(rl_pkt_count), 256'(2));
      idle_cycles(5);

      // 2: ipg=0, single-beat packets every cycle
      ipg_cycles = 32'd0;
      hs_before  = cyc;
      for (int i = 0; i < 8; i++) send_pkt(1);
      check("t2_cycles", 256'(cyc - hs_before), 256'(8));
      wait_drain("t2_drain");
      check("t2_s_gap", 256'(s_gap), 256'(0));
      check("t2_m_gap", 256'(m_gap), 256'(0));
      check("t2_pkt_count", 256'(rl_pkt_count), 256'(10));
      // clear in the same cycle as a tlast handshake: clear wins
      clear = 1'b1;
      drive_beat(1'b1);
      clear = 1'b0;
      check("t2_clear_prio", 256'(rl_pkt_count), 256'(0));
      wait_drain("t2_drain2");

      // 3: m_axis_tready toggling during a 6-beat packet
      ipg_cycles  = 32'd2;
      tready_mode = 1;
      send_pkt(6);
      wait_drain("t3_drain");
      tready_mode = 0;
      check("t3_pkt_count", 256'(rl_pkt_count), 256'(1));
      idle_cycles(5);

      // 4: rl_enable dropped after beat 2 of 5; packet still completes
      drive_beat(1'b0);
      drive_beat(1'b0);
      rl_enable = 1'b0;
      drive_beat(1'b0);
      drive_beat(1'b0);
      drive_beat(1'b1);
      wait_drain("t4_drain");
      check("t4_pkt_count", 256'(rl_pkt_count), 256'(2));
      hs_before = s_hs;
      present_beat(1'b1);
      repeat (8) begin
         @(posedge clk);
         #1;
      end
      check("t4_head_held", 256'(s_hs), 256'(hs_before));
      rl_enable = 1'b1;
      wait_accept();
      wait_drain("t4_drain2");
      check("t4_head_taken", 256'(s_hs), 256'(hs_before + 1));
      check("t4_pkt_count2", 256'(rl_pkt_count), 256'(3));
      idle_cycles(5);

      // 5: ipg changed 10->2 during a gap
      ipg_cycles = 32'd10;
      send_pkt(2);
      ipg_cycles = 32'd2;
      send_pkt(2);
      check("t5_gap10", 256'(s_gap), 256'(10));
      send_pkt(2);
      check("t5_gap2", 256'(s_gap), 256'(2));
      wait_drain("t5_drain");
      check("t5_m_gap2", 256'(m_gap), 256'(2));
      check("t5_pkt_count", 256'(rl_pkt_count), 256'(6));
      idle_cycles(5);

      // 6: stall statistics over a 6-cycle gap, then reset mid-packet
      clear = 1'b1;
      @(posedge clk);
      #1;
      clear = 1'b0;
      check("t6_clear", 256'(rl_pkt_count), 256'(0));
      ipg_cycles = 32'd6;
      send_pkt(1);
      drive_beat(1'b0);   // head held valid across the whole gap
`ifdef OSNT_RATE_LIMIT_STATS_EN
      check("t6_stall_count", 256'(rl_stall_count), 256'(6));
`endif
      check("t6_s_gap", 256'(s_gap), 256'(6));
      drive_beat(1'b0);
      s_axis_tvalid = 1'b0;
      axis_reset    = 1'b1;
      @(posedge clk);
      #1;
      check("t6_rst_m_tvalid", 256'(m_axis_tvalid), 256'(0));
      check("t6_rst_pkt_count", 256'(rl_pkt_count), 256'(0));
`ifdef OSNT_RATE_LIMIT_STATS_EN
      check("t6_rst_stall", 256'(rl_stall_count), 256'(0));
`endif
      sb.delete();
      axis_reset = 1'b0;
      @(negedge clk);
      check("t6_idle_ready", 256'(s_axis_tready), 256'(1));
      check("t6_no_out", 256'(m_axis_tvalid), 256'(0));
      @(posedge clk);
      #1;
      // A fresh packet flows normally after the reset
      ipg_cycles = 32'd1;
      send_pkt(3);
      wait_drain("t6_drain");
      check("t6_pkt_after_rst", 256'(rl_pkt_count), 256'(1));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_osnt_sume_10g_rate_limiter
